// File: rtl/de0_nano_top.sv
// DE0-Nano UART (8N1) command front end driving eight LEDs: 'L'+byte writes, 'R'/'E' read back LEDs/error count.
// LED write lands one cycle after the stop-bit sample; one response is held pending, and a newer request replaces it.
module de0_nano_top #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  output logic [7:0] gpio_o,
  input  logic       uart0_rxd_i,
  output logic       uart0_txd_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_sync;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart0_rxd_i;
      rx_sync <= rx_meta;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_valid, rx_ferr;
  logic [7:0]    err_cnt;

  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (rx_state == RX_STOP) && rx_tick && rx_sync;
    rx_ferr  = (rx_state == RX_STOP) && rx_tick && !rx_sync;
  end

  // Counter preloads to half a bit while idle so the start-bit re-check lands mid-bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: rx_cnt <= HALF_LAST;
        RX_START: begin
          if (rx_tick) begin
            rx_cnt <= BIT_LAST;
            rx_idx <= '0;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= BIT_LAST;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: if (!rx_tick) rx_cnt <= rx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                          err_cnt <= 8'h00;
    else if (rx_ferr && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  typedef enum logic {CMD_CMD, CMD_DATA} cmd_state_t;
  cmd_state_t cmd_state, cmd_next;
  logic       gpio_we, resp_req;
  logic [7:0] resp_val;
  logic       resp_pend;
  logic [7:0] resp_dat;
  logic       tx_load;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cmd_state <= CMD_CMD;
    else         cmd_state <= cmd_next;
  end

  always_comb begin
    cmd_next = cmd_state;
    case (cmd_state)
      CMD_CMD:  if (rx_valid && rx_shift == 8'h4C) cmd_next = CMD_DATA;
      CMD_DATA: if (rx_valid) cmd_next = CMD_CMD;
      default:  cmd_next = CMD_CMD;
    endcase
  end

  always_comb begin
    gpio_we  = (cmd_state == CMD_DATA) && rx_valid;
    resp_req = 1'b0;
    resp_val = gpio_o;
    if (cmd_state == CMD_CMD && rx_valid) begin
      if (rx_shift == 8'h52) begin
        resp_req = 1'b1;
        resp_val = gpio_o;
      end else if (rx_shift == 8'h45) begin
        resp_req = 1'b1;
        resp_val = err_cnt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      gpio_o <= 8'h00;
    else if (gpio_we) gpio_o <= rx_shift;
  end

  // A fresh request wins over a same-cycle load; the loaded byte is then the older one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_pend <= 1'b0;
      resp_dat  <= 8'h00;
    end else if (resp_req) begin
      resp_pend <= 1'b1;
      resp_dat  <= resp_val;
    end else if (tx_load) begin
      resp_pend <= 1'b0;
    end
  end

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx, tx_idx_next;
  logic [7:0]    tx_byte;
  logic          tx_tick, txd_next;

  assign tx_tick = (tx_cnt == '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (resp_pend) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_load     = (tx_state == TX_IDLE) && resp_pend;
    tx_idx_next = tx_idx;
    if (tx_state == TX_START)               tx_idx_next = 3'd0;
    else if (tx_state == TX_DATA && tx_tick) tx_idx_next = tx_idx + 3'd1;
    case (tx_next)
      TX_START: txd_next = 1'b0;
      TX_DATA:  txd_next = tx_byte[tx_idx_next];
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_byte     <= 8'h00;
      uart0_txd_o <= 1'b1;
    end else begin
      if (tx_load) begin
        tx_byte <= resp_dat;
        tx_cnt  <= BIT_LAST;
      end else if (tx_state != TX_IDLE) begin
        tx_cnt <= tx_tick ? BIT_LAST : tx_cnt - 1'b1;
      end
      tx_idx      <= tx_idx_next;
      uart0_txd_o <= txd_next;
    end
  end

endmodule

// File: tb/tb_de0_nano_top.sv
// Bench for de0_nano_top: random command traffic checked against a byte-level model of LEDs, error count and replies.
// Runs the UART at 16 clocks per bit to keep the simulation short.
module tb_de0_nano_top;

  localparam int CPB    = 16;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = CLK_HZ / CPB;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] gpio;
  logic       rxd;
  logic       txd;

  de0_nano_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .gpio_o      (gpio),
    .uart0_rxd_i (rxd),
    .uart0_txd_o (txd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: LED value, error count, awaiting-data flag, expected reply bytes.
  logic [7:0] m_led = 8'h00;
  int         m_err = 0;
  bit         m_data = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] gpio_at_stop;

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      if (m_err != 255) m_err++;
    end else if (m_data) begin
      m_led  = b;
      m_data = 1'b0;
    end else begin
      case (b)
        8'h4C: m_data = 1'b1;
        8'h52: exp_q.push_back(m_led);
        8'h45: exp_q.push_back(8'(m_err));
        default: ;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad, input int gap);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    gpio_at_stop = gpio;
    rxd = ~bad;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    model_byte(b, bad);
    repeat (gap + (bad ? 2 * CPB : 0)) @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 30 * CPB) begin
      @(negedge clk);
      t++;
    end
    check("tx_drain", exp_q.size(), 0);
  endtask

  // TX monitor: samples each bit mid-way, measures the start-bit length when bit 0 is 1.
  int         epoch = 0;
  int         n_frames = 0;
  int         mon_ep, mon_run;
  bit         mon_on;
  logic [9:0] mon_bits;
  logic [7:0] mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        mon_ep  = epoch;
        mon_run = 0;
        mon_on  = 1'b1;
        for (int n = 0; n < 10 * CPB; n++) begin
          if (n > 0) @(negedge clk);
          if (mon_on && txd === 1'b0) mon_run++;
          else mon_on = 1'b0;
          if (n % CPB == CPB / 2) mon_bits[n / CPB] = txd;
        end
        if (mon_ep == epoch) begin
          n_frames++;
          check("tx_start_bit", mon_bits[0], 0);
          check("tx_stop_bit", mon_bits[9], 1);
          if (exp_q.size() == 0) begin
            check("tx_unexpected_frame", exp_q.size(), 1);
          end else begin
            mon_exp = exp_q.pop_front();
            check("tx_byte", mon_bits[8:1], mon_exp);
            if (mon_exp[0]) check("tx_start_len", mon_run, CPB);
          end
        end
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int lows;
  int frames_before;
  int t;
  logic [7:0] rb;

  initial begin
    rxd  = 1'b0;
    rstn = 1'b0;
    #50;
    check("reset_gpio", gpio, 8'h00);
    check("reset_txd", txd, 1);
    #50;
    rstn = 1'b1;

    // Line held low from time zero: exactly one framing error, no frames out.
    lows = 0;
    repeat (30 * CPB) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    rxd = 1'b1;
    m_err = 1;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("held_low_txd_idle", lows, 0);
    check("held_low_gpio", gpio, 8'h00);
    send(8'h45, 1'b0, 0);
    wait_drain();

    frames_before = n_frames;
    send(8'h4C, 1'b0, 0);
    send(8'hA5, 1'b0, 0);
    check("led_write_not_early", gpio_at_stop, 8'h00);
    check("led_write", gpio, 8'hA5);
    repeat (2 * CPB) @(negedge clk);
    check("led_write_no_tx", n_frames, frames_before);

    send(8'h52, 1'b0, 0);
    wait_drain();

    frames_before = n_frames;
    send(8'h52, 1'b0, 0);
    send(8'h52, 1'b0, 0);
    wait_drain();
    check("rr_two_frames", n_frames, frames_before + 2);
    send(8'h00, 1'b0, 0);
    send(8'h78, 1'b0, 0);
    check("ignored_bytes_gpio", gpio, m_led);
    send(8'h52, 1'b0, 0);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rb = 8'h4C;
        1: rb = 8'h52;
        2: rb = 8'h45;
        default: rb = 8'($urandom);
      endcase
      send(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 2 * CPB));
      check("rand_gpio", gpio, m_led);
    end
    wait_drain();

    send(8'h00, 1'b0, 0);
    send(8'h4C, 1'b0, 0);
    send(8'h5A, 1'b0, 0);
    check("led_write_5a", gpio, 8'h5A);

    // Two-clock glitch must not start a frame or count an error.
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_gpio", gpio, 8'h5A);
    send(8'h45, 1'b0, 0);
    wait_drain();

    // Reset in the middle of a reply frame.
    send(8'h52, 1'b0, 0);
    t = 0;
    while (txd !== 1'b0 && t < 20 * CPB) begin
      @(negedge clk);
      t++;
    end
    check("tx_started_before_reset", txd, 0);
    repeat (3 * CPB) @(negedge clk);
    rstn = 1'b0;
    epoch++;
    #1;
    check("midtx_reset_txd", txd, 1);
    check("midtx_reset_gpio", gpio, 8'h00);
    exp_q.delete();
    m_led  = 8'h00;
    m_err  = 0;
    m_data = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (CPB) @(negedge clk);
    send(8'h45, 1'b0, 0);
    wait_drain();
    check("final_gpio", gpio, m_led);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
